// File: rtl/datapath_legv8_mc.sv
`default_nettype none
// ============================================================================
//  Module   : datapath_legv8_mc
//  Purpose  : Multi-cycle LEGv8 datapath. Accepts one decoded control word
//             per handshake and runs it through IDLE -> EXEC -> (MEM) -> WB.
//             Contains the register file (top register is XZR), the ALU and
//             the {V,C,N,Z} status register. Loads and stores go to an
//             external variable-latency memory over a req/ack handshake.
//  Ports    : clock, reset (async, active-low)
//             cw_valid / cw_ready          control-word handshake
//             sa, sb, da, reg_write, mem_read, mem_write, fs, b_sel,
//             set_flags, constant          control-word fields
//             done, result, status         write-back outputs
//             mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ack
//                                          data-memory handshake
//  Revision : 1.0 - initial release
// ============================================================================
module datapath_legv8_mc #(
   parameter  int DW   = 64,
   parameter  int REGS = 32,
   parameter  int AW   = 8,
   localparam int RA   = $clog2(REGS)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          cw_valid,
   output logic          cw_ready,
   input  logic [RA-1:0] sa,
   input  logic [RA-1:0] sb,
   input  logic [RA-1:0] da,
   input  logic          reg_write,
   input  logic          mem_read,
   input  logic          mem_write,
   input  logic [2:0]    fs,
   input  logic          b_sel,
   input  logic          set_flags,
   input  logic [DW-1:0] constant,
   output logic          done,
   output logic [DW-1:0] result,
   output logic [3:0]    status,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_MEM  = 2'd2,
      ST_WB   = 2'd3
   } state_t;

   localparam logic [2:0] c_fs_and  = 3'd0;
   localparam logic [2:0] c_fs_orr  = 3'd1;
   localparam logic [2:0] c_fs_add  = 3'd2;
   localparam logic [2:0] c_fs_sub  = 3'd3;
   localparam logic [2:0] c_fs_eor  = 3'd4;
   localparam logic [2:0] c_fs_lsl  = 3'd5;
   localparam logic [2:0] c_fs_lsr  = 3'd6;
   localparam logic [2:0] c_fs_pass = 3'd7;
   // REGS is a power of two, so the XZR index is all ones.
   localparam logic [RA-1:0] c_xzr = '1;

   state_t        state_q, state_d;
   logic [RA-1:0] da_q, da_d;
   logic          reg_write_q, reg_write_d;
   logic          mem_read_q, mem_read_d;
   logic          mem_write_q, mem_write_d;
   logic [2:0]    fs_q, fs_d;
   logic          b_sel_q, b_sel_d;
   logic          set_flags_q, set_flags_d;
   logic [DW-1:0] const_q, const_d;
   logic [DW-1:0] a_q, a_d;
   logic [DW-1:0] b_q, b_d;
   logic [DW-1:0] y_q, y_d;
   logic [DW-1:0] result_q, result_d;
   logic [3:0]    status_q, status_d;
   logic [DW-1:0] regs_q [REGS];
   logic [DW-1:0] regs_d [REGS];

   // ---------------------------------------------------------------- ALU
   logic [DW-1:0] w_bop;
   logic          w_sub;
   logic          w_arith;
   logic [DW-1:0] w_addend;
   logic [DW:0]   w_sum;
   logic          w_shift_big;
   logic [DW-1:0] w_y;
   logic [3:0]    w_flags;

   always_comb begin
      w_bop    = b_sel_q ? const_q : b_q;
      w_sub    = (fs_q == c_fs_sub);
      w_arith  = (fs_q == c_fs_add) || w_sub;
      // Subtraction is A + ~B + 1 so one adder yields both carry and overflow.
      w_addend = w_sub ? ~w_bop : w_bop;
      w_sum    = {1'b0, a_q} + {1'b0, w_addend} + {{DW{1'b0}}, w_sub};
      // Any set bit above the 6-bit amount field, or an amount >= DW, shifts
      // everything out.
      w_shift_big = (|w_bop[DW-1:6]) | ({26'd0, w_bop[5:0]} >= DW);
      w_y = '0;
      case (fs_q)
         c_fs_and:  w_y = a_q & w_bop;
         c_fs_orr:  w_y = a_q | w_bop;
         c_fs_add:  w_y = w_sum[DW-1:0];
         c_fs_sub:  w_y = w_sum[DW-1:0];
         c_fs_eor:  w_y = a_q ^ w_bop;
         c_fs_lsl:  w_y = w_shift_big ? '0 : (a_q << w_bop[5:0]);
         c_fs_lsr:  w_y = w_shift_big ? '0 : (a_q >> w_bop[5:0]);
         c_fs_pass: w_y = w_bop;
         default:   w_y = w_bop;
      endcase
      w_flags[3] = w_arith & (a_q[DW-1] == w_addend[DW-1]) & (w_y[DW-1] != a_q[DW-1]);
      w_flags[2] = w_arith & w_sum[DW];
      w_flags[1] = w_y[DW-1];
      w_flags[0] = (w_y == '0);
   end

   // ------------------------------------------------------ next-state logic
   always_comb begin
      state_d     = state_q;
      da_d        = da_q;
      reg_write_d = reg_write_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      fs_d        = fs_q;
      b_sel_d     = b_sel_q;
      set_flags_d = set_flags_q;
      const_d     = const_q;
      a_d         = a_q;
      b_d         = b_q;
      y_d         = y_q;
      result_d    = result_q;
      status_d    = status_q;
      regs_d      = regs_q;
      case (state_q)
         ST_IDLE: begin
            if (cw_valid) begin
               da_d        = da;
               reg_write_d = reg_write;
               mem_read_d  = mem_read;
               mem_write_d = mem_write;
               fs_d        = fs;
               b_sel_d     = b_sel;
               set_flags_d = set_flags;
               const_d     = constant;
               a_d         = (sa == c_xzr) ? '0 : regs_q[sa];
               b_d         = (sb == c_xzr) ? '0 : regs_q[sb];
               state_d     = ST_EXEC;
            end
         end
         ST_EXEC: begin
            y_d = w_y;
            if (set_flags_q) begin
               status_d = w_flags;
            end
            if (mem_read_q || mem_write_q) begin
               state_d = ST_MEM;
            end else begin
               // result is staged here so it is already valid during WB
               result_d = w_y;
               state_d  = ST_WB;
            end
         end
         ST_MEM: begin
            if (mem_ack) begin
               // A combined read+write is a plain store; WB keeps the ALU value.
               result_d = (mem_read_q && !mem_write_q) ? mem_rdata : y_q;
               state_d  = ST_WB;
            end
         end
         ST_WB: begin
            if (reg_write_q && (da_q != c_xzr)) begin
               regs_d[da_q] = result_q;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         da_q        <= '0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         fs_q        <= '0;
         b_sel_q     <= 1'b0;
         set_flags_q <= 1'b0;
         const_q     <= '0;
         a_q         <= '0;
         b_q         <= '0;
         y_q         <= '0;
         result_q    <= '0;
         status_q    <= '0;
         for (int i = 0; i < REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         da_q        <= da_d;
         reg_write_q <= reg_write_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         fs_q        <= fs_d;
         b_sel_q     <= b_sel_d;
         set_flags_q <= set_flags_d;
         const_q     <= const_d;
         a_q         <= a_d;
         b_q         <= b_d;
         y_q         <= y_d;
         result_q    <= result_d;
         status_q    <= status_d;
         regs_q      <= regs_d;
      end
   end

   // -------------------------------------------------------------- outputs
   // All handshake outputs decode the state register, so an asynchronous
   // reset drops an in-flight request immediately.
   assign cw_ready  = (state_q == ST_IDLE);
   assign done      = (state_q == ST_WB);
   assign mem_req   = (state_q == ST_MEM);
   assign mem_we    = mem_req & mem_write_q;
   assign mem_addr  = mem_req ? y_q[AW-1:0] : '0;
   assign mem_wdata = mem_req ? b_q : '0;
   assign result    = result_q;
   assign status    = status_q;

endmodule
`default_nettype wire

// File: tb/tb_datapath_legv8_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_datapath_legv8_mc
//  Purpose  : Self-checking bench for datapath_legv8_mc (default parameters).
//             Table of ALU vectors plus directed multi-cycle sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_datapath_legv8_mc;

   logic        clock;
   logic        reset;
   logic        cw_valid;
   logic        cw_ready;
   logic [4:0]  sa, sb, da;
   logic        reg_write, mem_read, mem_write, b_sel, set_flags;
   logic [2:0]  fs;
   logic [63:0] cw_const;
   logic        done;
   logic [63:0] result;
   logic [3:0]  status;
   logic        mem_req, mem_we;
   logic [7:0]  mem_addr;
   logic [63:0] mem_wdata, mem_rdata;
   logic        mem_ack;

   datapath_legv8_mc dut (
      .clock     (clock),
      .reset     (reset),
      .cw_valid  (cw_valid),
      .cw_ready  (cw_ready),
      .sa        (sa),
      .sb        (sb),
      .da        (da),
      .reg_write (reg_write),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .fs        (fs),
      .b_sel     (b_sel),
      .set_flags (set_flags),
      .constant  (cw_const),
      .done      (done),
      .result    (result),
      .status    (status),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int checks   = 0;
   int failures = 0;

   // ---------------------------------------------------------- memory model
   logic [63:0] mem_model [256];
   logic        mem_en;
   logic        manual_ack;
   int          ack_delay;
   int          req_cycles;

   initial begin
      for (int i = 0; i < 256; i++) mem_model[i] = 64'd0;
      mem_ack    = 1'b0;
      mem_rdata  = 64'd0;
      req_cycles = 0;
      forever begin
         @(negedge clock);
         if (!mem_en) begin
            mem_ack = manual_ack;
         end else if (mem_req && !mem_ack) begin
            req_cycles++;
            if (req_cycles == ack_delay) begin
               mem_ack   = 1'b1;
               mem_rdata = mem_model[mem_addr];
               if (mem_we) mem_model[mem_addr] = mem_wdata;
            end
         end else if (mem_ack) begin
            mem_ack    = 1'b0;
            req_cycles = 0;
         end
      end
   end

   // Memory-side observations collected while an op runs.
   int          mcyc;
   logic [7:0]  m_addr;
   logic        m_we;
   logic [63:0] m_wdata;
   logic        m_unstable;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      @(negedge clock);
      while (!cw_ready && w < 100) begin
         @(negedge clock);
         w++;
      end
      if (!cw_ready) chk("idle_timeout", {63'd0, cw_ready}, 64'd1);
   endtask

   // Issues one control word and waits for done. lat counts cycles inclusively,
   // the accept cycle being cycle 1.
   task automatic run_op(input logic [4:0] sa_i, input logic [4:0] sb_i, input logic [4:0] da_i,
                         input logic rw, input logic mr, input logic mwr,
                         input logic [2:0] fs_i, input logic bs, input logic sf,
                         input logic [63:0] k, input int ack_dly,
                         output logic [63:0] res, output int lat);
      wait_idle();
      ack_delay  = ack_dly;
      req_cycles = 0;
      mcyc       = 0;
      m_unstable = 1'b0;
      m_addr     = 8'd0;
      m_we       = 1'b0;
      m_wdata    = 64'd0;
      sa = sa_i; sb = sb_i; da = da_i;
      reg_write = rw; mem_read = mr; mem_write = mwr;
      fs = fs_i; b_sel = bs; set_flags = sf; cw_const = k;
      cw_valid = 1'b1;
      @(posedge clock); #1;
      cw_valid = 1'b0;
      lat = 2;
      while (!done && lat < 100) begin
         @(posedge clock); #1;
         lat++;
         if (mem_req) begin
            if (mcyc == 0) begin
               m_addr = mem_addr; m_we = mem_we; m_wdata = mem_wdata;
            end else if (mem_addr !== m_addr || mem_we !== m_we || mem_wdata !== m_wdata) begin
               m_unstable = 1'b1;
            end
            mcyc++;
         end
      end
      if (!done) chk("done_timeout", {63'd0, done}, 64'd1);
      res = result;
   endtask

   task automatic read_reg(input logic [4:0] r, output logic [63:0] v);
      int l;
      run_op(5'd0, r, 5'd31, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 64'd0, 1, v, l);
   endtask

   typedef struct {
      logic [2:0]  fs;
      logic        bs;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp_y;
      logic [3:0]  exp_st;   // {V,C,N,Z}
   } vec_t;

   vec_t vecs [13];

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] res, v;
      int          lat;

      vecs[0]  = '{3'd0, 1'b0, 64'hF0F0,               64'hFF00,               64'hF000,               4'b0000};
      vecs[1]  = '{3'd1, 1'b0, 64'hF0F0,               64'h0F0F,               64'hFFFF,               4'b0000};
      vecs[2]  = '{3'd2, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,                  64'h8000_0000_0000_0000, 4'b1010};
      vecs[3]  = '{3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                  64'd0,                  4'b0101};
      vecs[4]  = '{3'd3, 1'b0, 64'd5,                  64'd5,                  64'd0,                  4'b0101};
      vecs[5]  = '{3'd3, 1'b1, 64'd3,                  64'd5,                  64'hFFFF_FFFF_FFFF_FFFE, 4'b0010};
      vecs[6]  = '{3'd3, 1'b0, 64'h8000_0000_0000_0000, 64'd1,                  64'h7FFF_FFFF_FFFF_FFFF, 4'b1100};
      vecs[7]  = '{3'd4, 1'b0, 64'hFF,                 64'h0F,                 64'hF0,                 4'b0000};
      vecs[8]  = '{3'd5, 1'b1, 64'h8000_0000_0000_0000, 64'd64,                 64'd0,                  4'b0001};
      vecs[9]  = '{3'd6, 1'b1, 64'h8000_0000_0000_0000, 64'd63,                 64'd1,                  4'b0000};
      vecs[10] = '{3'd5, 1'b0, 64'd1,                  64'd4,                  64'h10,                 4'b0000};
      vecs[11] = '{3'd7, 1'b1, 64'h1234,               64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 4'b0010};
      vecs[12] = '{3'd0, 1'b0, 64'hF0,                 64'h0F,                 64'd0,                  4'b0001};

      reset = 1'b0; cw_valid = 1'b0;
      sa = '0; sb = '0; da = '0; reg_write = 0; mem_read = 0; mem_write = 0;
      fs = '0; b_sel = 0; set_flags = 0; cw_const = '0;
      mem_en = 1'b1; manual_ack = 1'b0; ack_delay = 1;

      // ---- reset state
      repeat (3) @(posedge clock);
      #1;
      chk("rst_ctrl {ready,done,req,we}", {60'd0, cw_ready, done, mem_req, mem_we}, 64'b1000);
      chk("rst_addr_wdata", {mem_addr, mem_wdata[55:0]} | {56'd0, mem_wdata[63:56]}, 64'd0);
      chk("rst_status", {60'd0, status}, 64'd0);
      chk("rst_result", result, 64'd0);
      @(negedge clock);
      reset = 1'b1;

      // ---- ADD X1 = XZR + 5, then SUB X2 = X1 - X1 with flags
      run_op(5'd31, 5'd0, 5'd1, 1, 0, 0, 3'd2, 1, 0, 64'd5, 1, res, lat);
      chk("add_x1_result", res, 64'd5);
      chk("add_x1_latency", 64'(lat), 64'd3);
      run_op(5'd1, 5'd1, 5'd2, 1, 0, 0, 3'd3, 0, 1, 64'd0, 1, res, lat);
      chk("sub_x2_result", res, 64'd0);
      chk("sub_x2_status", {60'd0, status}, 64'b0101);
      chk("sub_x2_latency", 64'(lat), 64'd3);
      read_reg(5'd1, v);
      chk("read_x1", v, 64'd5);

      // ---- ALU table
      for (int i = 0; i < 13; i++) begin
         run_op(5'd0, 5'd0, 5'd10, 1, 0, 0, 3'd7, 1, 0, vecs[i].a, 1, res, lat);
         run_op(5'd0, 5'd0, 5'd11, 1, 0, 0, 3'd7, 1, 0, vecs[i].b, 1, res, lat);
         run_op(5'd10, 5'd11, 5'd12, 1, 0, 0, vecs[i].fs, vecs[i].bs, 1, vecs[i].b, 1, res, lat);
         chk($sformatf("vec%0d_y", i), res, vecs[i].exp_y);
         chk($sformatf("vec%0d_status", i), {60'd0, status}, {60'd0, vecs[i].exp_st});
      end
      read_reg(5'd12, v);
      chk("read_x12", v, 64'd0);

      // status must hold through an op without set_flags
      run_op(5'd0, 5'd0, 5'd13, 1, 0, 0, 3'd7, 1, 0, 64'h8000_0000_0000_0000, 1, res, lat);
      chk("noflags_status_held", {60'd0, status}, 64'b0001);

      // ---- store X3 = 0xDEAD to 0x10 with ack on the third MEM cycle
      run_op(5'd0, 5'd0, 5'd3, 1, 0, 0, 3'd7, 1, 0, 64'hDEAD, 1, res, lat);
      run_op(5'd31, 5'd3, 5'd0, 0, 0, 1, 3'd2, 1, 0, 64'h10, 3, res, lat);
      chk("store_mem_cycles", 64'(mcyc), 64'd3);
      chk("store_we", {63'd0, m_we}, 64'd1);
      chk("store_addr", {56'd0, m_addr}, 64'h10);
      chk("store_wdata", m_wdata, 64'hDEAD);
      chk("store_stable", {63'd0, m_unstable}, 64'd0);
      chk("store_latency", 64'(lat), 64'd6);
      chk("store_mem_content", mem_model[8'h10], 64'hDEAD);

      // ---- load X4 from 0x10, ack on third MEM cycle
      run_op(5'd31, 5'd0, 5'd4, 1, 1, 0, 3'd2, 1, 0, 64'h10, 3, res, lat);
      chk("load_result", res, 64'hDEAD);
      chk("load_latency", 64'(lat), 64'd6);
      chk("load_we", {63'd0, m_we}, 64'd0);
      read_reg(5'd4, v);
      chk("read_x4", v, 64'hDEAD);

      // ---- load acked in the first MEM cycle
      run_op(5'd31, 5'd0, 5'd5, 1, 1, 0, 3'd2, 1, 0, 64'h10, 1, res, lat);
      chk("fastload_latency", 64'(lat), 64'd4);
      chk("fastload_result", res, 64'hDEAD);

      // ---- read and write together behaves as a store; WB keeps Y
      run_op(5'd31, 5'd3, 5'd6, 1, 1, 1, 3'd2, 1, 0, 64'h11, 2, res, lat);
      chk("rw_result_is_y", res, 64'h11);
      chk("rw_we", {63'd0, m_we}, 64'd1);
      chk("rw_mem_content", mem_model[8'h11], 64'hDEAD);
      chk("rw_latency", 64'(lat), 64'd5);

      // ---- write to XZR, with a second cw_valid during EXEC
      wait_idle();
      sa = 5'd31; sb = 5'd0; da = 5'd31; reg_write = 1; mem_read = 0; mem_write = 0;
      fs = 3'd7; b_sel = 1; set_flags = 0; cw_const = 64'd9; cw_valid = 1'b1;
      @(posedge clock); #1;
      da = 5'd7; cw_const = 64'd77;
      chk("xzr_exec_not_ready", {63'd0, cw_ready}, 64'd0);
      @(posedge clock); #1;
      chk("xzr_done", {63'd0, done}, 64'd1);
      chk("xzr_result", result, 64'd9);
      cw_valid = 1'b0;
      @(posedge clock); #1;
      chk("xzr_done_pulse", {62'd0, done, cw_ready}, 64'b01);
      read_reg(5'd31, v);
      chk("read_x31", v, 64'd0);
      read_reg(5'd7, v);
      chk("read_x7_untouched", v, 64'd0);

      // ---- reset in the middle of a MEM wait
      mem_en = 1'b0;
      manual_ack = 1'b0;
      wait_idle();
      sa = 5'd31; sb = 5'd3; da = 5'd0; reg_write = 0; mem_read = 0; mem_write = 1;
      fs = 3'd2; b_sel = 1; set_flags = 0; cw_const = 64'h20; cw_valid = 1'b1;
      @(posedge clock); #1;
      cw_valid = 1'b0;
      mem_write = 0;
      @(posedge clock); #1;
      chk("mid_mem_req", {63'd0, mem_req}, 64'd1);
      @(posedge clock); #1;
      chk("mid_mem_req_held", {63'd0, mem_req}, 64'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst_ctrl {ready,done,req,we}", {60'd0, cw_ready, done, mem_req, mem_we}, 64'b1000);
      chk("async_rst_addr", {56'd0, mem_addr}, 64'd0);
      chk("async_rst_wdata", mem_wdata, 64'd0);
      chk("async_rst_status", {60'd0, status}, 64'd0);
      chk("async_rst_result", result, 64'd0);
      @(negedge clock);
      reset = 1'b1;
      #1;
      manual_ack = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(posedge clock); #1;
         chk($sformatf("late_ack%0d {ready,done,req}", c), {61'd0, cw_ready, done, mem_req}, 64'b100);
      end
      manual_ack = 1'b0;
      @(negedge clock);
      @(negedge clock);
      mem_en = 1'b1;
      read_reg(5'd1, v);
      chk("post_rst_x1", v, 64'd0);
      read_reg(5'd4, v);
      chk("post_rst_x4", v, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
